pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the MEM_WAIT cycle count at which timeout_o sets.
REQ-002 SHALL have ports: clk_i  in  1  clock; all state updates on the rising edge.
REQ-003 SHALL have ports: rst_i  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: id_ex_memrd_i  in  1  instruction in EX is a load.
REQ-005 SHALL have ports: ex_rt_i  in  5  load destination register in EX.
REQ-006 SHALL have ports: id_rs_i, id_rt_i  in  5 each  source registers of the instruction in ID.
REQ-007 SHALL have ports: branch_taken_i  in  1  branch resolved taken in ID.
REQ-008 SHALL have ports: mem_req_i  in  1  MEM stage issues a data-cache access.
REQ-009 SHALL have ports: mem_ack_i  in  1  data cache completes the access this cycle.
REQ-010 SHALL have ports: clr_cnt_i  in  1  synchronous clear of both counters and of timeout_o.
REQ-011 SHALL have ports: pc_wr_o, if_id_wr_o, ex_mem_wr_o, mem_wb_wr_o  out  1 each  pipeline-register write enables.
REQ-012 SHALL have ports: id_ex_bubble_o  out  1  insert NOP into ID/EX.
REQ-013 SHALL have ports: if_id_flush_o  out  1  clear IF/ID.
REQ-014 SHALL have ports: stall_cnt_o, flush_cnt_o  out  16 each  performance counters.
REQ-015 SHALL have ports: state_o  out  2  FSM state: 0=RUN, 1=MEM_WAIT.
REQ-016 SHALL have ports: timeout_o  out  1  sticky memory-timeout flag.

Function
REQ-017 SHALL define freeze = (RUN & mem_req_i & !mem_ack_i) | (MEM_WAIT & !mem_ack_i).
REQ-018 SHALL define lu_hazard = id_ex_memrd_i & (ex_rt_i != 0) & ((id_rs_i == ex_rt_i) | (id_rt_i == ex_rt_i)); register 0 never causes a stall.
REQ-019 SHALL prioritise freeze > lu_hazard > branch_taken_i; at most one action per cycle.
REQ-020 SHALL, on freeze: drive all four write enables 0, id_ex_bubble_o 0 and if_id_flush_o 0 (whole pipe holds).
REQ-021 SHALL, on lu_hazard without freeze: drive pc_wr_o=0, if_id_wr_o=0, id_ex_bubble_o=1, ex_mem_wr_o=1, mem_wb_wr_o=1 and if_id_flush_o=0.
REQ-022 SHALL, on branch_taken_i without freeze or lu_hazard: drive if_id_flush_o=1 and all write enables 1.
REQ-023 SHALL otherwise drive all write enables 1 and bubble/flush 0; all outputs in REQ-020..023 are combinational from state and inputs.
REQ-024 SHALL transition RUN->MEM_WAIT when mem_req_i=1 and mem_ack_i=0; RUN stays RUN on a hit (req and ack in the same cycle).
REQ-025 SHALL transition MEM_WAIT->RUN on mem_ack_i=1, with freeze released in that ack cycle; mem_req_i is ignored in MEM_WAIT.
REQ-026 SHALL count MEM_WAIT cycles in an 8-bit wait counter, zeroed on entry to MEM_WAIT; timeout_o sets when the count reaches TIMEOUT and stays set until clr_cnt_i or reset; the FSM keeps waiting after timeout.
REQ-027 SHALL increment stall_cnt_o each cycle pc_wr_o=0 and flush_cnt_o each cycle if_id_flush_o=1, saturating at 16'hFFFF.
REQ-028 SHALL give clr_cnt_i priority over increment: a cleared counter reads 0 the next cycle.
REQ-029 SHALL treat a branch coinciding with lu_hazard as dropped this cycle; it is re-evaluated when ID re-presents it next cycle.

Reset
REQ-030 SHALL, while rst_i=0, force state RUN, counters 0, wait counter 0 and timeout_o 0.
REQ-031 SHALL, while rst_i=0, drive all write enables 0, id_ex_bubble_o 0 and if_id_flush_o 0, regardless of other inputs.
REQ-032 SHALL, if reset asserts in MEM_WAIT, abandon the access and return to RUN; an ack arriving during reset is ignored.

Verification
REQ-033 SHALL test: memrd=1, ex_rt=5, id_rs=5 -> pc_wr=0, if_id_wr=0, bubble=1 for one cycle; stall_cnt goes 0->1.
REQ-034 SHALL test: memrd=1, ex_rt=0, id_rs=0 -> no stall, all write enables 1.
REQ-035 SHALL test: mem_req=1 with ack arriving 3 cycles later -> state_o=1 for 3 cycles; all write enables 0 for 3 cycles, 1 in the ack cycle; stall_cnt +3.
REQ-036 SHALL test: lu_hazard and branch_taken in the same cycle -> flush=0, bubble=1; branch alone next cycle -> flush=1, flush_cnt +1.
REQ-037 SHALL test: mem_req held with no ack for TIMEOUT=255 cycles -> timeout_o=1 and remains set; clr_cnt_i=1 -> timeout_o=0 and counters 0 the next cycle.
REQ-038 SHALL test: rst_i pulled low mid-MEM_WAIT -> state_o=0 immediately, counters 0, all write enables 0 until release.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush and
// data-cache miss freeze with a sticky memory-timeout flag and perf counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | pipe flows; a cache miss (req without ack) freezes it and exits
// MEM_WAIT | waiting for the data cache; pipe frozen until mem_ack_i
module pipe_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_ex_memrd_i,
    input  logic [4:0]  ex_rt_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    input  logic        clr_cnt_i,
    output logic        pc_wr_o,
    output logic        if_id_wr_o,
    output logic        ex_mem_wr_o,
    output logic        mem_wb_wr_o,
    output logic        id_ex_bubble_o,
    output logic        if_id_flush_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic [1:0]  state_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt;
    logic       freeze;
    logic       lu_hazard;
    logic       wait_tc;

    assign state_o = state_q;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu_hazard = id_ex_memrd_i && (ex_rt_i != 5'd0) &&
                       ((id_rs_i == ex_rt_i) || (id_rt_i == ex_rt_i));

    assign wait_tc = ({24'd0, wait_cnt} + 32'd1) >= TIMEOUT;

    always_comb begin
        state_d        = state_q;
        freeze         = 1'b0;
        pc_wr_o        = 1'b1;
        if_id_wr_o     = 1'b1;
        ex_mem_wr_o    = 1'b1;
        mem_wb_wr_o    = 1'b1;
        id_ex_bubble_o = 1'b0;
        if_id_flush_o  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) state_d = RUN;
                else           freeze  = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (freeze) begin
            pc_wr_o     = 1'b0;
            if_id_wr_o  = 1'b0;
            ex_mem_wr_o = 1'b0;
            mem_wb_wr_o = 1'b0;
        end else if (lu_hazard) begin
            // A coincident taken branch is dropped; ID re-presents it next cycle.
            pc_wr_o        = 1'b0;
            if_id_wr_o     = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
        end

        if (!rst_i) begin
            pc_wr_o        = 1'b0;
            if_id_wr_o     = 1'b0;
            ex_mem_wr_o    = 1'b0;
            mem_wb_wr_o    = 1'b0;
            id_ex_bubble_o = 1'b0;
            if_id_flush_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wait_cnt    <= 8'd0;
            timeout_o   <= 1'b0;
            stall_cnt_o <= 16'd0;
            flush_cnt_o <= 16'd0;
        end else begin
            state_q <= state_d;

            if (state_q == RUN && state_d == MEM_WAIT)
                wait_cnt <= 8'd0;
            else if (state_q == MEM_WAIT && wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;

            // Timeout only flags; the FSM keeps waiting for the ack.
            if (clr_cnt_i)
                timeout_o <= 1'b0;
            else if (state_q == MEM_WAIT && wait_tc)
                timeout_o <= 1'b1;

            if (clr_cnt_i)
                stall_cnt_o <= 16'd0;
            else if (!pc_wr_o && stall_cnt_o != 16'hFFFF)
                stall_cnt_o <= stall_cnt_o + 16'd1;

            if (clr_cnt_i)
                flush_cnt_o <= 16'd0;
            else if (if_id_flush_o && flush_cnt_o != 16'hFFFF)
                flush_cnt_o <= flush_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed hazard/miss/timeout/reset scenarios
// followed by random traffic, all checked against a cycle-level reference model.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 255;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_ex_memrd_i;
    logic [4:0]  ex_rt_i, id_rs_i, id_rt_i;
    logic        branch_taken_i, mem_req_i, mem_ack_i, clr_cnt_i;
    logic        pc_wr_o, if_id_wr_o, ex_mem_wr_o, mem_wb_wr_o;
    logic        id_ex_bubble_o, if_id_flush_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;
    logic [1:0]  state_o;
    logic        timeout_o;

    pipe_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_ex_memrd_i(id_ex_memrd_i), .ex_rt_i(ex_rt_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i),
        .mem_ack_i(mem_ack_i), .clr_cnt_i(clr_cnt_i),
        .pc_wr_o(pc_wr_o), .if_id_wr_o(if_id_wr_o),
        .ex_mem_wr_o(ex_mem_wr_o), .mem_wb_wr_o(mem_wb_wr_o),
        .id_ex_bubble_o(id_ex_bubble_o), .if_id_flush_o(if_id_flush_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
        .state_o(state_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: waiting flag, cycles spent waiting, sticky flag, counters.
    bit m_wait;
    int m_wcnt;
    bit m_to;
    int m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic set_in(input bit rd, input int rt, input int rs, input int rtid,
                          input bit br, input bit rq, input bit ak, input bit clr);
        id_ex_memrd_i = rd; ex_rt_i = 5'(rt); id_rs_i = 5'(rs); id_rt_i = 5'(rtid);
        branch_taken_i = br; mem_req_i = rq; mem_ack_i = ak; clr_cnt_i = clr;
    endtask

    // One clock: called at negedge with inputs already applied.
    task automatic tick();
        bit frz, haz, e_hold, e_bub, e_fl, e_pc, e_idw, e_back;
        #1;
        frz = m_wait ? !mem_ack_i : (mem_req_i && !mem_ack_i);
        haz = id_ex_memrd_i && ex_rt_i != 0 && (id_rs_i == ex_rt_i || id_rt_i == ex_rt_i);
        e_hold = frz;
        e_bub  = !frz && haz;
        e_fl   = !frz && !haz && branch_taken_i;
        e_pc   = !(frz || haz);
        e_idw  = e_pc;
        e_back = !frz;
        if (!rst_i) begin
            e_bub = 0; e_fl = 0; e_pc = 0; e_idw = 0; e_back = 0;
        end
        chk("pc_wr",     {31'd0, pc_wr_o},        {31'd0, e_pc});
        chk("if_id_wr",  {31'd0, if_id_wr_o},     {31'd0, e_idw});
        chk("ex_mem_wr", {31'd0, ex_mem_wr_o},    {31'd0, e_back});
        chk("mem_wb_wr", {31'd0, mem_wb_wr_o},    {31'd0, e_back});
        chk("bubble",    {31'd0, id_ex_bubble_o}, {31'd0, e_bub});
        chk("flush",     {31'd0, if_id_flush_o},  {31'd0, e_fl});
        @(posedge clk_i);
        if (!rst_i) model_reset();
        else begin
            if (clr_cnt_i) begin
                m_stall = 0; m_flush = 0; m_to = 0;
            end else begin
                if (!e_pc) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
                if (e_fl)  m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
                if (m_wait && m_wcnt + 1 >= TIMEOUT) m_to = 1;
            end
            if (m_wait) begin
                m_wcnt = (m_wcnt < 255) ? m_wcnt + 1 : 255;
                if (mem_ack_i) m_wait = 0;
            end else if (mem_req_i && !mem_ack_i) begin
                m_wait = 1; m_wcnt = 0;
            end
        end
        #1;
        chk("state",     {30'd0, state_o},     m_wait ? 32'd1 : 32'd0);
        chk("stall_cnt", {16'd0, stall_cnt_o}, 32'(m_stall));
        chk("flush_cnt", {16'd0, flush_cnt_o}, 32'(m_flush));
        chk("timeout",   {31'd0, timeout_o},   {31'd0, m_to});
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk_i);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_pc_wr", {31'd0, pc_wr_o}, 32'd0);
        do_reset();

        // Load-use on rs: one-cycle stall, stall_cnt 0 -> 1.
        set_in(1, 5, 5, 9, 0, 0, 0, 0); tick();
        chk("lu_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);
        // Load to r0 never stalls.
        set_in(1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("r0_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);

        // Miss: req then ack three cycles later.
        set_in(0, 0, 0, 0, 0, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 0); tick();
        chk("miss_stall_cnt", {16'd0, stall_cnt_o}, 32'd4);
        chk("miss_state", {30'd0, state_o}, 32'd0);

        // Hit: req and ack together, no state change.
        set_in(0, 0, 0, 0, 0, 1, 1, 0); tick();

        // Load-use with branch: branch dropped, then flushed next cycle.
        set_in(1, 7, 3, 7, 1, 0, 0, 0); tick();
        set_in(0, 7, 3, 7, 1, 0, 0, 0); tick();
        chk("branch_flush_cnt", {16'd0, flush_cnt_o}, 32'd1);

        // Timeout after TIMEOUT wait cycles, sticky, cleared by clr_cnt_i.
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) tick();
        chk("to_before", {31'd0, timeout_o}, 32'd0);
        tick();
        chk("to_set", {31'd0, timeout_o}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("to_sticky", {31'd0, timeout_o}, 32'd1);
        set_in(0, 0, 0, 0, 1, 1, 1, 1); tick();
        chk("to_clr", {31'd0, timeout_o}, 32'd0);
        chk("clr_stall", {16'd0, stall_cnt_o}, 32'd0);

        // Reset asserted mid-wait: immediate return to RUN, outputs held low.
        set_in(0, 0, 0, 0, 0, 1, 0, 0); tick(); tick();
        rst_i = 1'b0;
        model_reset();
        #1;
        chk("arst_state", {30'd0, state_o}, 32'd0);
        chk("arst_stall", {16'd0, stall_cnt_o}, 32'd0);
        chk("arst_pc_wr", {31'd0, pc_wr_o}, 32'd0);
        set_in(1, 4, 4, 4, 1, 1, 1, 0); tick(); tick();
        rst_i = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0); tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 40) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
